// File: rtl/irrigation_zone_sequencer.sv
// Multi-zone irrigation controller: debounced sensors, tank refill with hysteresis/timeout,
// and a round-robin zone watering sequencer (sprinkler or dripper per visit).
module irrigation_zone_sequencer #(
  parameter int ZONES           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_CYCLES      = 1024,
  parameter int FILL_TIMEOUT    = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             low_water_level,
  input  logic             mid_water_level,
  input  logic             high_water_level,
  input  logic [ZONES-1:0] earth_humidity,
  input  logic             air_humidity,
  input  logic             low_temperature,
  output logic             water_supply_valvule,
  output logic [ZONES-1:0] splinker_bomb,
  output logic [ZONES-1:0] dripper_valvule,
  output logic             alarm,
  output logic [2:0]       active_zone,
  output logic [1:0]       seq_state
);

  localparam int NS  = ZONES + 5;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW  = $clog2(RUN_CYCLES + 1);
  localparam int FW  = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WATER = 2'd1, REST = 2'd2, FAULT = 2'd3} state_t;

  logic [NS-1:0]    raw, filt;
  logic             low_f, mid_f, high_f, air_f, temp_f;
  logic [ZONES-1:0] earth_f;
  logic [7:0]       earth_pad;

  assign raw = {earth_humidity, low_temperature, air_humidity,
                high_water_level, mid_water_level, low_water_level};

  // Filtered bit follows the synchronised input only after a full run of differing samples.
  for (genvar gi = 0; gi < NS; gi++) begin : g_deb
    logic [1:0]     sync_reg;
    logic [DBW-1:0] cnt_reg;
    logic           filt_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_reg <= '0;
        cnt_reg  <= '0;
        filt_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[0], raw[gi]};
        if (sync_reg[1] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DBW'(DEBOUNCE_CYCLES - 1)) begin
          filt_reg <= sync_reg[1];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
    assign filt[gi] = filt_reg;
  end

  assign low_f     = filt[0];
  assign mid_f     = filt[1];
  assign high_f    = filt[2];
  assign air_f     = filt[3];
  assign temp_f    = filt[4];
  assign earth_f   = filt[NS-1:5];
  assign earth_pad = 8'(earth_f);

  state_t         state_reg, state_next;
  logic [2:0]     active_reg, active_next;
  logic [2:0]     scan_reg, scan_next;
  logic           mode_reg, mode_next;
  logic [RW-1:0]  run_cnt_reg, run_cnt_next;
  logic [2:0]     rest_cnt_reg, rest_cnt_next;
  logic           armed_reg, valve_hold_reg, fill_fault_reg;
  logic [FW-1:0]  fill_cnt_reg;
  logic           conflict, fault_any, valve_open, sprinkle_sel;

  assign conflict     = (high_f & ~mid_f) | (mid_f & ~low_f);
  assign fault_any    = conflict | fill_fault_reg;
  assign sprinkle_sel = ~air_f & ~temp_f & mid_f;
  // Hysteresis: opens below mid, closes at high, otherwise keeps its previous state.
  assign valve_open   = armed_reg & (state_reg != FAULT) & ~high_f & (~mid_f | valve_hold_reg);

  // Candidate zones in round-robin order starting at the scan pointer.
  logic [3:0]       cand_sum [ZONES];
  logic [2:0]       cand_idx [ZONES];
  logic [ZONES-1:0] cand_dry;
  logic [ZONES-1:0] zone_sel;
  for (genvar gi = 0; gi < ZONES; gi++) begin : g_scan
    assign cand_sum[gi] = {1'b0, scan_reg} + 4'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= 4'(ZONES)) ? 3'(cand_sum[gi] - 4'(ZONES))
                                                      : cand_sum[gi][2:0];
    assign cand_dry[gi] = ~earth_pad[cand_idx[gi]];
    assign zone_sel[gi] = (active_reg == 3'(gi));
  end

  logic       found;
  logic [2:0] dry_idx;
  always_comb begin
    found   = 1'b0;
    dry_idx = scan_reg;
    for (int i = 0; i < ZONES; i++) begin
      if (!found && cand_dry[i]) begin
        found   = 1'b1;
        dry_idx = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    active_next   = active_reg;
    scan_next     = scan_reg;
    mode_next     = mode_reg;
    run_cnt_next  = '0;
    rest_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (fault_any) begin
          state_next = FAULT;
        end else if (low_f && found) begin
          state_next  = WATER;
          active_next = dry_idx;
          mode_next   = sprinkle_sel;
        end
      end
      WATER: begin
        if (fault_any) begin
          state_next = FAULT;
        end else if (earth_pad[active_reg] || !low_f || run_cnt_reg == RW'(RUN_CYCLES - 1)) begin
          state_next = REST;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end
      REST: begin
        if (fault_any) begin
          state_next = FAULT;
        end else if (rest_cnt_reg == 3'd7) begin
          state_next = IDLE;
          scan_next  = (32'(active_reg) + 1 >= ZONES) ? 3'd0 : active_reg + 3'd1;
        end else begin
          rest_cnt_next = rest_cnt_reg + 3'd1;
        end
      end
      default: begin
        if (!fault_any) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      active_reg     <= '0;
      scan_reg       <= '0;
      mode_reg       <= 1'b0;
      run_cnt_reg    <= '0;
      rest_cnt_reg   <= '0;
      armed_reg      <= 1'b0;
      valve_hold_reg <= 1'b0;
      fill_cnt_reg   <= '0;
      fill_fault_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      active_reg     <= active_next;
      scan_reg       <= scan_next;
      mode_reg       <= mode_next;
      run_cnt_reg    <= run_cnt_next;
      rest_cnt_reg   <= rest_cnt_next;
      armed_reg      <= 1'b1;
      valve_hold_reg <= valve_open;
      if (valve_open) begin
        if (fill_cnt_reg != FW'(FILL_TIMEOUT)) fill_cnt_reg <= fill_cnt_reg + 1'b1;
        if (fill_cnt_reg == FW'(FILL_TIMEOUT - 1)) fill_fault_reg <= 1'b1;
      end else begin
        fill_cnt_reg <= '0;
      end
    end
  end

  assign water_supply_valvule = valve_open;
  assign splinker_bomb   = (state_reg == WATER &&  mode_reg) ? zone_sel : '0;
  assign dripper_valvule = (state_reg == WATER && !mode_reg) ? zone_sel : '0;
  assign alarm           = (state_reg == FAULT) | (~mid_f & low_f);
  assign active_zone     = active_reg;
  assign seq_state       = state_reg;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Directed bench for irrigation_zone_sequencer with shortened timing parameters
// (debounce 4, run 40, fill timeout 300); filtered sensors lag raw inputs by 6 cycles.
module tb_irrigation_zone_sequencer;
  localparam int ZONES = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             low_water_level, mid_water_level, high_water_level;
  logic [ZONES-1:0] earth_humidity;
  logic             air_humidity, low_temperature;
  logic             water_supply_valvule;
  logic [ZONES-1:0] splinker_bomb, dripper_valvule;
  logic             alarm;
  logic [2:0]       active_zone;
  logic [1:0]       seq_state;

  int n_checks = 0;
  int n_pass   = 0;

  irrigation_zone_sequencer #(
    .ZONES(ZONES), .DEBOUNCE_CYCLES(4), .RUN_CYCLES(40), .FILL_TIMEOUT(300)
  ) dut (
    .clock(clock), .reset(reset),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level), .earth_humidity(earth_humidity),
    .air_humidity(air_humidity), .low_temperature(low_temperature),
    .water_supply_valvule(water_supply_valvule), .splinker_bomb(splinker_bomb),
    .dripper_valvule(dripper_valvule), .alarm(alarm),
    .active_zone(active_zone), .seq_state(seq_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valve"}, 32'(water_supply_valvule), 32'd0);
    chk({tag, "_spr"},   32'(splinker_bomb),        32'd0);
    chk({tag, "_drip"},  32'(dripper_valvule),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    low_water_level = 0; mid_water_level = 0; high_water_level = 0;
    earth_humidity = 4'b1111; air_humidity = 0; low_temperature = 0;
    cyc(2);
    chk_quiet("rst");
    chk("rst_alarm",  32'(alarm),       32'd0);
    chk("rst_zone",   32'(active_zone), 32'd0);
    chk("rst_state",  32'(seq_state),   32'd0);

    // Refill from an empty tank.
    reset = 1'b0;
    cyc(5);  chk("fill_open", 32'(water_supply_valvule), 32'd1);
    low_water_level = 1;
    cyc(8);  chk("low_alarm", 32'(alarm), 32'd1);
    mid_water_level = 1;
    cyc(8);  chk("hyst_hold_open", 32'(water_supply_valvule), 32'd1);
    chk("mid_no_alarm", 32'(alarm), 32'd0);
    high_water_level = 1;
    cyc(5);  chk("close_minus1", 32'(water_supply_valvule), 32'd1);
    cyc(1);  chk("close_exact",  32'(water_supply_valvule), 32'd0);
    high_water_level = 0;
    cyc(10); chk("hyst_stay_closed", 32'(water_supply_valvule), 32'd0);

    // Zones 1 and 3 dry, humid air: dripper mode, round robin.
    air_humidity = 1; earth_humidity = 4'b0101;
    cyc(7);  chk("z1_drip", 32'(dripper_valvule), 32'h2);
    chk("z1_spr", 32'(splinker_bomb), 32'h0);
    chk("z1_state", 32'(seq_state), 32'd1);
    chk("z1_zone", 32'(active_zone), 32'd1);
    cyc(39); chk("z1_drip_end", 32'(dripper_valvule), 32'h2);
    cyc(1);  chk("z1_timeout_off", 32'(dripper_valvule), 32'h0);
    chk("z1_rest", 32'(seq_state), 32'd2);
    cyc(7);  chk("rest_last", 32'(seq_state), 32'd2);
    cyc(1);  chk("rest_done", 32'(seq_state), 32'd0);
    cyc(1);  chk("z3_drip", 32'(dripper_valvule), 32'h8);
    chk("z3_zone", 32'(active_zone), 32'd3);
    earth_humidity = 4'b1111;
    cyc(6);  chk("z3_wet_pending", 32'(dripper_valvule), 32'h8);
    cyc(1);  chk("z3_wet_off", 32'(dripper_valvule), 32'h0);
    cyc(8);  chk("z3_idle", 32'(seq_state), 32'd0);

    // Zone 2 dry, dry warm air: sprinkler mode, wet mid-run.
    air_humidity = 0; earth_humidity = 4'b1011;
    cyc(7);  chk("z2_spr", 32'(splinker_bomb), 32'h4);
    chk("z2_drip", 32'(dripper_valvule), 32'h0);
    chk("z2_zone", 32'(active_zone), 32'd2);
    cyc(3);  earth_humidity = 4'b1111;
    cyc(6);  chk("z2_wet_pending", 32'(splinker_bomb), 32'h4);
    cyc(1);  chk("z2_wet_off", 32'(splinker_bomb), 32'h0);
    chk("z2_rest", 32'(seq_state), 32'd2);
    cyc(8);  chk("z2_idle", 32'(seq_state), 32'd0);

    // Level conflict (high without mid) and self-recovery.
    high_water_level = 1; mid_water_level = 0;
    cyc(6);  chk("conf_pending", 32'(seq_state), 32'd0);
    cyc(1);  chk("conf_fault", 32'(seq_state), 32'd3);
    chk("conf_alarm", 32'(alarm), 32'd1);
    cyc(13); chk("conf_hold", 32'(seq_state), 32'd3);
    chk_quiet("conf");
    mid_water_level = 1;
    cyc(6);  chk("conf_clear_pending", 32'(seq_state), 32'd3);
    cyc(1);  chk("conf_recover", 32'(seq_state), 32'd0);
    chk("conf_alarm_off", 32'(alarm), 32'd0);

    // Fill timeout: valve open without high ever rising.
    high_water_level = 0; mid_water_level = 0;
    cyc(7);  chk("to_open", 32'(water_supply_valvule), 32'd1);
    chk("to_low_alarm", 32'(alarm), 32'd1);
    cyc(299); chk("to_before", 32'(seq_state), 32'd0);
    cyc(1);  chk("to_fault", 32'(seq_state), 32'd3);
    chk("to_valve_closed", 32'(water_supply_valvule), 32'd0);
    high_water_level = 1; mid_water_level = 1;
    cyc(20); chk("to_sticky", 32'(seq_state), 32'd3);
    chk("to_sticky_alarm", 32'(alarm), 32'd1);
    reset = 1'b1;
    #1;
    chk_quiet("to_rst");
    chk("to_rst_state", 32'(seq_state), 32'd0);
    chk("to_rst_alarm", 32'(alarm), 32'd0);

    // Reset while zone 0 is watering clears outputs without a clock edge.
    @(negedge clock);
    reset = 1'b0; air_humidity = 1; earth_humidity = 4'b1110;
    cyc(7);  chk("z0_drip", 32'(dripper_valvule), 32'h1);
    chk("z0_state", 32'(seq_state), 32'd1);
    cyc(5);
    #2 reset = 1'b1;
    #1;
    chk("async_drip", 32'(dripper_valvule), 32'h0);
    chk("async_spr",  32'(splinker_bomb),   32'h0);
    chk("async_state", 32'(seq_state),      32'd0);
    chk("async_zone", 32'(active_zone),     32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
